// File: rtl/dev_rsp_collector.sv
// Device fabric return path: tracks issued device IDs in order and forwards
// response beats to the initiator strictly in issue order. DNON requests get
// a locally generated error response.
package params_pkg;
  localparam int unsigned DATA_W = 256;
  typedef enum logic [2:0] {
    DRAM = 3'd0,
    DROM = 3'd1,
    DMAT = 3'd2,
    DINT = 3'd3,
    DREG = 3'd4,
    DEXE = 3'd5,
    DSPI = 3'd6,
    DNON = 3'd7
  } did_t;
endpackage

module dev_rsp_collector
  import params_pkg::*;
#(
  parameter int unsigned DATA_W = params_pkg::DATA_W,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid_i,
  input  logic [2:0]                   issue_did_i,
  output logic                         issue_ready_o,
  input  logic [6:0]                   dev_rsp_valid_i,
  input  logic [7*DATA_W-1:0]          dev_rsp_data_i,
  output logic [6:0]                   dev_rsp_ready_o,
  output logic                         rsp_valid_o,
  output logic [DATA_W-1:0]            rsp_data_o,
  output logic [2:0]                   rsp_did_o,
  output logic                         rsp_err_o,
  input  logic                         rsp_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {EMPTY, FULL} ostate_t;

  did_t              fifo [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  ostate_t           st;
  ostate_t           st_nxt;
  did_t              head;
  logic              head_vld;
  logic              can_load;
  logic              load;
  logic              push;
  logic              drain;
  logic [7:0]        vld_ext;
  logic [7:0]        head_onehot;
  logic [DATA_W-1:0] dev_data [8];

  // Slot 7 (DNON) has no device behind it; it reads as zero so the head can
  // index the array without a range check.
  for (genvar g = 0; g < 7; g++) begin : g_unpack
    assign dev_data[g] = dev_rsp_data_i[g*DATA_W +: DATA_W];
  end
  assign dev_data[7] = '0;

  assign head          = fifo[rptr];
  assign head_vld      = (count != '0);
  assign can_load      = (st == EMPTY) || rsp_ready_i;
  assign vld_ext       = {1'b0, dev_rsp_valid_i};
  assign head_onehot   = 8'd1 << head;
  // A DNON head lands on bit 7, which is dropped, so no device is acknowledged.
  assign dev_rsp_ready_o = (head_vld && can_load) ? head_onehot[6:0] : '0;
  assign load          = head_vld && can_load && ((head == DNON) || vld_ext[head]);
  assign issue_ready_o = (count < CW'(DEPTH));
  assign push          = issue_valid_i && issue_ready_o;
  assign drain         = rsp_valid_o && rsp_ready_i;
  assign rsp_valid_o   = (st == FULL);
  assign outstanding_o = count;

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= EMPTY;
    else        st <= st_nxt;
  end

  // Output stage next state: a load always wins over a drain (pass-through).
  always_comb begin
    st_nxt = st;
    if (load)       st_nxt = FULL;
    else if (drain) st_nxt = EMPTY;
  end

  // Tracking FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (load) rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(load);
    end
  end

  // Tracking FIFO storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= did_t'(issue_did_i);
  end

  // Response payload register, loaded from the head device or the DNON error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_o <= '0;
      rsp_did_o  <= '0;
      rsp_err_o  <= 1'b0;
    end else if (load) begin
      if (head == DNON) begin
        rsp_data_o <= '0;
        rsp_did_o  <= 3'd7;
        rsp_err_o  <= 1'b1;
      end else begin
        rsp_data_o <= dev_data[head];
        rsp_did_o  <= head;
        rsp_err_o  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dev_rsp_collector.sv
// Bench for dev_rsp_collector: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_dev_rsp_collector;
  localparam int DW    = 256;
  localparam int DEPTH = 8;

  typedef logic [DW-1:0] data_t;
  typedef struct {
    logic [2:0] did;
    data_t      data;
    logic       err;
    int         cyc;
  } out_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              issue_valid = 1'b0;
  logic [2:0]        issue_did = '0;
  logic              issue_ready;
  logic [6:0]        dev_valid = '0;
  logic [7*DW-1:0]   dev_data = '0;
  logic [6:0]        dev_ready;
  logic              rsp_valid;
  data_t             rsp_data;
  logic [2:0]        rsp_did;
  logic              rsp_err;
  logic              rsp_ready = 1'b0;
  logic [3:0]        outstanding;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    max_out = 0;
  bit    issue_acc;
  data_t pend [7][$];
  out_t  olog [$];

  // reference model state
  int    mq [$];
  bit    m_valid = 0;
  data_t m_data;
  logic [2:0] m_did;
  bit    m_err;

  always #5 clk = ~clk;

  dev_rsp_collector #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid_i   (issue_valid),
    .issue_did_i     (issue_did),
    .issue_ready_o   (issue_ready),
    .dev_rsp_valid_i (dev_valid),
    .dev_rsp_data_i  (dev_data),
    .dev_rsp_ready_o (dev_ready),
    .rsp_valid_o     (rsp_valid),
    .rsp_data_o      (rsp_data),
    .rsp_did_o       (rsp_did),
    .rsp_err_o       (rsp_err),
    .rsp_ready_i     (rsp_ready),
    .outstanding_o   (outstanding)
  );

  task automatic chk(input string name, input data_t act, input data_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic data_t rnd_data();
    data_t v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: in-order queue of issued IDs plus a one-entry output slot.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_valid = 0;
    end else begin
      bit can_ld;
      bit ld;
      bit do_push;
      int sz;
      sz      = mq.size();
      can_ld  = !m_valid || rsp_ready;
      do_push = issue_valid && (sz < DEPTH);
      ld      = 0;
      if (sz > 0 && can_ld) begin
        if (mq[0] == 7) begin
          ld = 1; m_data = '0; m_did = 3'd7; m_err = 1;
        end else if (dev_valid[mq[0]]) begin
          ld = 1; m_data = dev_data[mq[0]*DW +: DW]; m_did = mq[0][2:0]; m_err = 0;
        end
      end
      if (ld) begin
        m_valid = 1;
        void'(mq.pop_front());
      end else if (m_valid && rsp_ready) begin
        m_valid = 0;
      end
      if (do_push) mq.push_back(int'(issue_did));
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    logic [6:0] exp_ready;
    @(negedge clk);
    cyc++;
    exp_ready = '0;
    if (mq.size() > 0 && mq[0] != 7 && (!m_valid || rsp_ready)) exp_ready[mq[0]] = 1'b1;
    chk("dev_ready", dev_ready, exp_ready);
    chk("issue_ready", issue_ready, mq.size() < DEPTH);
    chk("outstanding", outstanding, mq.size());
    chk("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_did", rsp_did, m_did);
      chk("rsp_err", rsp_err, m_err);
    end
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
    if (rsp_valid && rsp_ready) olog.push_back('{did: rsp_did, data: rsp_data, err: rsp_err, cyc: cyc});
  end

  task automatic drive_devs();
    for (int d = 0; d < 7; d++) begin
      dev_valid[d] = (pend[d].size() > 0);
      dev_data[d*DW +: DW] = (pend[d].size() > 0) ? pend[d][0] : '0;
    end
  endtask

  // One clock: handshakes are sampled mid-cycle, inputs updated 1 after the edge.
  task automatic cycle();
    logic [6:0] hs;
    bit iacc;
    @(negedge clk);
    hs   = dev_valid & dev_ready;
    iacc = issue_valid && issue_ready;
    @(posedge clk);
    #1;
    for (int d = 0; d < 7; d++) if (hs[d]) void'(pend[d].pop_front());
    drive_devs();
    issue_acc = iacc;
  endtask

  task automatic do_issue(input int d);
    bit got;
    got = 0;
    issue_valid = 1'b1;
    issue_did   = 3'(d);
    for (int i = 0; i < 100 && !got; i++) begin
      cycle();
      got = issue_acc;
    end
    issue_valid = 1'b0;
    chk("issue_accepted", got, 1);
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && olog.size() < n; i++) cycle();
    chk("wait_responses", olog.size() >= n, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_did"}, rsp_did, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_dev_ready"}, dev_ready, 0);
    chk({tag, "_issue_ready"}, issue_ready, 1);
  endtask

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    cycle();
    chk_reset_vals("after_reset");

    // in-order return: DROM, DRAM, DREG
    rsp_ready = 1'b1;
    olog.delete();
    do_issue(1);
    do_issue(0);
    do_issue(4);
    pend[0].push_back('hA);
    pend[4].push_back('hB);
    drive_devs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("order_dram_stalled", dev_ready[0], 0);
      chk("order_dreg_stalled", dev_ready[4], 0);
    end
    pend[1].push_back('hC);
    drive_devs();
    wait_log(3, 20);
    if (olog.size() >= 3) begin
      chk("order0_did", olog[0].did, 1);  chk("order0_data", olog[0].data, 'hC);
      chk("order1_did", olog[1].did, 0);  chk("order1_data", olog[1].data, 'hA);
      chk("order2_did", olog[2].did, 4);  chk("order2_data", olog[2].data, 'hB);
    end
    repeat (2) cycle();

    // DNON error response two cycles after issue
    rsp_ready   = 1'b0;
    issue_valid = 1'b1;
    issue_did   = 3'd7;
    cycle();
    issue_valid = 1'b0;
    chk("dnon_n1_valid", rsp_valid, 0);
    cycle();
    chk("dnon_valid", rsp_valid, 1);
    chk("dnon_err", rsp_err, 1);
    chk("dnon_did", rsp_did, 7);
    chk("dnon_data", rsp_data, 0);
    rsp_ready = 1'b1;
    repeat (2) cycle();

    // full and wrap
    for (int i = 0; i < DEPTH; i++) do_issue(2);
    chk("full_issue_ready", issue_ready, 0);
    chk("full_outstanding", outstanding, 8);
    olog.delete();
    pend[2].push_back('0);
    drive_devs();
    issue_valid = 1'b1;
    issue_did   = 3'd2;
    cycle();
    issue_valid = 1'b0;
    chk("full_issue_refused", issue_acc, 0);
    chk("full_after_pop", outstanding, 7);
    for (int i = 1; i < 16; i++) pend[2].push_back(data_t'(i));
    drive_devs();
    for (int i = 0; i < DEPTH; i++) do_issue(2);
    wait_log(16, 100);
    for (int i = 0; i < 16 && i < olog.size(); i++) begin
      chk("wrap_data", olog[i].data, data_t'(i));
      chk("wrap_did", olog[i].did, 2);
    end
    repeat (2) cycle();
    chk("wrap_empty", outstanding, 0);

    // backpressure with pass-through on release
    rsp_ready = 1'b0;
    do_issue(6);
    do_issue(3);
    pend[6].push_back('h55);
    pend[3].push_back('h66);
    drive_devs();
    repeat (4) cycle();
    chk("bp_valid", rsp_valid, 1);
    chk("bp_hold_data", rsp_data, 'h55);
    chk("bp_hold_did", rsp_did, 6);
    chk("bp_dint_blocked", dev_ready[3], 0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_dint_ready", dev_ready[3], 1);
    cycle();
    chk("bp_pass_valid", rsp_valid, 1);
    chk("bp_pass_data", rsp_data, 'h66);
    chk("bp_pass_did", rsp_did, 3);
    cycle();
    chk("bp_drained", rsp_valid, 0);

    // streaming DEXE
    olog.delete();
    max_out = 0;
    for (int i = 1; i <= 16; i++) pend[5].push_back(data_t'(i));
    drive_devs();
    for (int i = 0; i < 16; i++) do_issue(5);
    wait_log(16, 100);
    for (int i = 0; i < 16 && i < olog.size(); i++) chk("stream_data", olog[i].data, data_t'(i + 1));
    if (olog.size() >= 16) chk("stream_rate", olog[15].cyc - olog[0].cyc, 15);
    chk("stream_max_out", max_out <= DEPTH, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_did   = 3'($urandom_range(0, 7));
      rsp_ready   = ($urandom_range(0, 3) != 0);
      for (int d = 0; d < 7; d++)
        if (pend[d].size() < 3 && $urandom_range(0, 3) == 0) pend[d].push_back(rnd_data());
      drive_devs();
      cycle();
    end
    issue_valid = 1'b0;

    // reset mid-stream with three outstanding and a stalled response
    for (int d = 0; d < 7; d++) pend[d].delete();
    drive_devs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    do_issue(1);
    do_issue(2);
    do_issue(4);
    pend[2].push_back('h99);
    drive_devs();
    cycle();
    chk("mid_outstanding", outstanding, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    for (int d = 0; d < 7; d++) pend[d].delete();
    drive_devs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    olog.delete();
    do_issue(0);
    pend[0].push_back('h77);
    drive_devs();
    wait_log(1, 20);
    if (olog.size() >= 1) begin
      chk("post_reset_did", olog[0].did, 0);
      chk("post_reset_data", olog[0].data, 'h77);
      chk("post_reset_err", olog[0].err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
